// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end: key codes and the
// keypad scanner state encoding.
package calc_pkg;

    localparam int KEY_W = 4;

    localparam logic [KEY_W-1:0] KEY_0   = 4'd0;
    localparam logic [KEY_W-1:0] KEY_1   = 4'd1;
    localparam logic [KEY_W-1:0] KEY_2   = 4'd2;
    localparam logic [KEY_W-1:0] KEY_3   = 4'd3;
    localparam logic [KEY_W-1:0] KEY_4   = 4'd4;
    localparam logic [KEY_W-1:0] KEY_5   = 4'd5;
    localparam logic [KEY_W-1:0] KEY_6   = 4'd6;
    localparam logic [KEY_W-1:0] KEY_7   = 4'd7;
    localparam logic [KEY_W-1:0] KEY_8   = 4'd8;
    localparam logic [KEY_W-1:0] KEY_9   = 4'd9;
    localparam logic [KEY_W-1:0] KEY_ADD = 4'd10;
    localparam logic [KEY_W-1:0] KEY_SUB = 4'd11;
    localparam logic [KEY_W-1:0] KEY_MUL = 4'd12;
    localparam logic [KEY_W-1:0] KEY_DIV = 4'd13;
    localparam logic [KEY_W-1:0] KEY_EQ  = 4'd14;
    localparam logic [KEY_W-1:0] KEY_CLR = 4'd15;

    typedef enum logic [1:0] {
        SCAN,
        PRESS_DB,
        HELD,
        RELEASE_DB
    } scan_state_t;

endpackage

// File: rtl/keypad_debounce.sv
// Stable-level counter: reports when level has held the same value for N
// consecutive cycles since the last start.
module keypad_debounce #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic level,
    output logic stable_hi,
    output logic stable_lo
);

    localparam int W = $clog2(N) + 1;
    localparam logic [W-1:0] LIMIT = W'(N);

    logic [W-1:0] cnt;
    logic [W-1:0] run_len;
    logic         last;

    // run_len is the length of the current run including this cycle; it
    // saturates at N so the counter can never wrap.
    always_comb begin
        run_len = cnt + W'(1);
        if (cnt != '0 && level != last) begin
            run_len = W'(1);
        end else if (cnt == LIMIT) begin
            run_len = LIMIT;
        end
    end

    assign stable_hi = level && (run_len == LIMIT);
    assign stable_lo = !level && (run_len == LIMIT);

    always_ff @(posedge clk) begin
        if (reset || start) begin
            cnt  <= '0;
            last <= 1'b0;
        end else begin
            cnt  <= run_len;
            last <= level;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Host-side 4x4 keypad scanner: rotates a one-hot column strobe, debounces
// press and release of the first key found and reports its code.
module keypad_scanner #(
    parameter int COLS            = 4,
    parameter int ROWS            = 4,
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic [COLS-1:0] col,
    input  logic [ROWS-1:0] row,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_down
);

    import calc_pkg::*;

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int SW = $clog2(SCAN_DIV) + 1;

    scan_state_t      state, state_d;
    logic [SW-1:0]    scan_cnt, scan_cnt_d;
    logic [COLS-1:0]  col_d, col_rot;
    logic [RW-1:0]    cand_row, cand_row_d;
    logic [KEY_W-1:0] cand_code, cand_code_d;
    logic [KEY_W-1:0] key_code_d;
    logic             key_valid_d, key_down_d;
    logic             dwell_done, row_hit, cand_level;
    logic             db_start, stable_hi, stable_lo;

    // Highest set row index wins, i.e. the lowest code in the column.
    function automatic logic [RW-1:0] top_row(input logic [ROWS-1:0] r);
        top_row = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (r[i]) top_row = RW'(i);
        end
    endfunction

    function automatic logic [CW-1:0] col_index(input logic [COLS-1:0] c);
        col_index = '0;
        for (int i = 0; i < COLS; i++) begin
            if (c[i]) col_index = CW'(i);
        end
    endfunction

    function automatic logic [KEY_W-1:0] encode(input logic [RW-1:0] r,
                                                input logic [CW-1:0] c);
        encode = KEY_W'((ROWS - 1 - int'(r)) * COLS + int'(c));
    endfunction

    assign col_rot    = {col[COLS-2:0], col[COLS-1]};
    assign dwell_done = (scan_cnt == SW'(SCAN_DIV - 1));
    assign row_hit    = |row;
    assign cand_level = row[cand_row];

    keypad_debounce #(
        .N(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .start     (db_start),
        .level     (cand_level),
        .stable_hi (stable_hi),
        .stable_lo (stable_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col       <= COLS'(1);
            scan_cnt  <= '0;
            cand_row  <= '0;
            cand_code <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_d;
            col       <= col_d;
            scan_cnt  <= scan_cnt_d;
            cand_row  <= cand_row_d;
            cand_code <= cand_code_d;
            key_code  <= key_code_d;
            key_valid <= key_valid_d;
            key_down  <= key_down_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            SCAN: begin
                if (dwell_done && row_hit) state_d = PRESS_DB;
            end
            PRESS_DB: begin
                if (!cand_level)    state_d = SCAN;
                else if (stable_hi) state_d = HELD;
            end
            HELD: begin
                if (!cand_level) state_d = RELEASE_DB;
            end
            RELEASE_DB: begin
                if (cand_level)     state_d = HELD;
                else if (stable_lo) state_d = SCAN;
            end
            default: state_d = SCAN;
        endcase
    end

    // The column only moves while scanning, or when a press is abandoned
    // or a release completes; otherwise it stays on the candidate key.
    always_comb begin
        col_d       = col;
        scan_cnt_d  = scan_cnt;
        cand_row_d  = cand_row;
        cand_code_d = cand_code;
        key_code_d  = key_code;
        key_valid_d = 1'b0;
        key_down_d  = key_down;
        db_start    = 1'b0;
        case (state)
            SCAN: begin
                if (!dwell_done) begin
                    scan_cnt_d = scan_cnt + SW'(1);
                end else begin
                    scan_cnt_d = '0;
                    if (row_hit) begin
                        cand_row_d  = top_row(row);
                        cand_code_d = encode(top_row(row), col_index(col));
                        db_start    = 1'b1;
                    end else begin
                        col_d = col_rot;
                    end
                end
            end
            PRESS_DB: begin
                if (!cand_level) begin
                    col_d = col_rot;
                end else if (stable_hi) begin
                    key_valid_d = 1'b1;
                    key_code_d  = cand_code;
                    key_down_d  = 1'b1;
                end
            end
            HELD: begin
                if (!cand_level) db_start = 1'b1;
            end
            RELEASE_DB: begin
                if (!cand_level && stable_lo) begin
                    key_down_d = 1'b0;
                    col_d      = col_rot;
                end
            end
            default: col_d = COLS'(1);
        endcase
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with a behavioural 4x4 keypad: a table of single
// presses plus hand-timed debounce and reset sequences.
module tb_keypad_scanner;

    import calc_pkg::*;

    logic        clk;
    logic        reset;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] keys;

    int total;
    int bad;
    int cyc;
    int pulses;
    int pulse_cyc;
    logic [3:0] pulse_code;
    logic [3:0] pulse_col;

    typedef struct {
        logic [15:0] keys;
        int          hold;
        int          exp_pulses;
        logic [3:0]  exp_code;
        logic [3:0]  exp_col;
    } vec_t;

    vec_t vecs[10];

    keypad_scanner dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Keypad model: row r is high when a pressed key sits in the strobed column.
    always_comb begin
        row = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col[c] && keys[(3 - r) * 4 + c]) row[r] = 1'b1;
            end
        end
    end

    function automatic logic [15:0] key_bit(input logic [3:0] k);
        logic [15:0] m;
        m = '0;
        m[k] = 1'b1;
        return m;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got,
                                input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic observe();
        total++;
        if (!$onehot(col)) begin
            bad++;
            $display("[TB] FAIL col_onehot (cycle %0d): got %b expected one-hot", cyc, col);
        end
        if (key_valid === 1'b1) begin
            pulses++;
            pulse_cyc  = cyc;
            pulse_code = key_code;
            pulse_col  = col;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        observe();
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        keys  = '0;
        @(negedge clk);
        @(negedge clk);
        reset     = 1'b0;
        cyc       = 0;
        pulses    = 0;
        pulse_cyc = -1;
        observe();
    endtask

    task automatic apply_stimulus(input vec_t v);
        pulses = 0;
        keys   = v.keys;
        repeat (v.hold) step();
        keys = '0;
        repeat (30) step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        keys  = '0;
        reset = 1'b1;

        vecs[0] = '{key_bit(KEY_6), 40, 1, KEY_6, 4'b0100};
        vecs[1] = '{key_bit(KEY_CLR), 5, 0, KEY_6, 4'b0000};
        vecs[2] = '{key_bit(KEY_1) | key_bit(KEY_DIV), 40, 1, KEY_1, 4'b0010};
        vecs[3] = '{key_bit(KEY_0), 40, 1, KEY_0, 4'b0001};
        vecs[4] = '{key_bit(KEY_MUL), 40, 1, KEY_MUL, 4'b0001};
        vecs[5] = '{key_bit(KEY_3), 40, 1, KEY_3, 4'b1000};
        vecs[6] = '{key_bit(KEY_EQ), 40, 1, KEY_EQ, 4'b0100};
        vecs[7] = '{key_bit(KEY_9), 40, 1, KEY_9, 4'b0010};
        vecs[8] = '{key_bit(KEY_SUB), 3, 0, KEY_9, 4'b0000};
        vecs[9] = '{key_bit(KEY_2) | key_bit(KEY_ADD), 40, 1, KEY_2, 4'b0100};

        // Reset values, then key 6 from cycle 20: sampled on 0100 at cycle 27.
        do_reset();
        check_output("reset_col", 32'(col), 32'(4'b0001));
        check_output("reset_code", 32'(key_code), 32'd0);
        check_output("reset_valid", 32'(key_valid), 32'd0);
        check_output("reset_down", 32'(key_down), 32'd0);
        wait_until(20);
        keys = key_bit(KEY_6);
        wait_until(35);
        check_output("k6_no_early_valid", 32'(pulses), 32'd0);
        wait_until(36);
        check_output("k6_valid_count", 32'(pulses), 32'd1);
        check_output("k6_valid_cycle", 32'(pulse_cyc), 32'd36);
        check_output("k6_code", 32'(pulse_code), 32'(KEY_6));
        check_output("k6_col", 32'(pulse_col), 32'(4'b0100));
        while (cyc < 60) begin
            step();
            check_output("k6_held_down", 32'(key_down), 32'd1);
        end
        keys = '0;
        wait_until(68);
        check_output("k6_down_before_release", 32'(key_down), 32'd1);
        wait_until(69);
        check_output("k6_released", 32'(key_down), 32'd0);
        check_output("k6_col_after_release", 32'(col), 32'(4'b1000));
        wait_until(73);
        check_output("k6_col_wrap", 32'(col), 32'(4'b0001));
        wait_until(77);
        check_output("k6_col_next", 32'(col), 32'(4'b0010));
        wait_until(90);
        check_output("k6_single_valid", 32'(pulses), 32'd1);

        // Key 15 held only 5 cycles: press abandoned, scanning moves on.
        do_reset();
        wait_until(14);
        keys = key_bit(KEY_CLR);
        wait_until(19);
        keys = '0;
        check_output("k15_col_held", 32'(col), 32'(4'b1000));
        wait_until(20);
        check_output("k15_col_resumed", 32'(col), 32'(4'b0001));
        wait_until(24);
        check_output("k15_col_next", 32'(col), 32'(4'b0010));
        wait_until(45);
        check_output("k15_no_valid", 32'(pulses), 32'd0);
        check_output("k15_no_down", 32'(key_down), 32'd0);

        // Keys 1 and 13 together, then 1 alone, then 9 added while 1 is held.
        do_reset();
        wait_until(2);
        keys = key_bit(KEY_1) | key_bit(KEY_DIV);
        wait_until(10);
        keys = key_bit(KEY_1);
        wait_until(16);
        check_output("k1_valid_cycle", 32'(pulse_cyc), 32'd16);
        check_output("k1_code", 32'(pulse_code), 32'(KEY_1));
        wait_until(20);
        keys = key_bit(KEY_1) | key_bit(KEY_9);
        wait_until(40);
        check_output("k1_still_down", 32'(key_down), 32'd1);
        check_output("k1_code_kept", 32'(key_code), 32'(KEY_1));
        keys = '0;
        wait_until(50);
        check_output("k1_released", 32'(key_down), 32'd0);
        wait_until(80);
        check_output("k1_single_valid", 32'(pulses), 32'd1);

        // Release bounce on '+', then reset while key 4 is being debounced.
        do_reset();
        wait_until(2);
        keys = key_bit(KEY_ADD);
        wait_until(20);
        check_output("kadd_valid_cycle", 32'(pulse_cyc), 32'd20);
        check_output("kadd_code", 32'(pulse_code), 32'(KEY_ADD));
        wait_until(30);
        keys = '0;
        wait_until(33);
        keys = key_bit(KEY_ADD);
        wait_until(35);
        keys = '0;
        while (cyc < 43) begin
            step();
            check_output("kadd_down_through_bounce", 32'(key_down), 32'd1);
        end
        wait_until(44);
        check_output("kadd_released", 32'(key_down), 32'd0);
        check_output("kadd_col_after_release", 32'(col), 32'(4'b1000));
        check_output("kadd_single_valid", 32'(pulses), 32'd1);
        wait_until(46);
        keys = key_bit(KEY_4);
        wait_until(55);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_output("rst_col", 32'(col), 32'(4'b0001));
        check_output("rst_valid", 32'(key_valid), 32'd0);
        check_output("rst_down", 32'(key_down), 32'd0);
        check_output("rst_code", 32'(key_code), 32'd0);
        wait_until(67);
        check_output("k4_no_early_valid", 32'(pulses), 32'd1);
        wait_until(68);
        check_output("k4_valid_count", 32'(pulses), 32'd2);
        check_output("k4_valid_cycle", 32'(pulse_cyc), 32'd68);
        check_output("k4_code", 32'(pulse_code), 32'(KEY_4));
        keys = '0;
        wait_until(90);

        // Table of single presses from an idle scanner.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(vecs[i]);
            check_output($sformatf("vec%0d_pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
            if (vecs[i].exp_pulses > 0) begin
                check_output($sformatf("vec%0d_col", i), 32'(pulse_col), 32'(vecs[i].exp_col));
            end
            check_output($sformatf("vec%0d_code", i), 32'(key_code), 32'(vecs[i].exp_code));
            check_output($sformatf("vec%0d_down", i), 32'(key_down), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
